// File: rtl/branch_resolve_ctrl.sv
// branch_resolve_ctrl
//   Sequences branch-prediction recovery for the 5-stage MIPS pipeline.
//   Every fetched beq/bne is queued with its predicted direction and the PC
//   that applies if that prediction is wrong. EX resolves the oldest entry.
//   A mispredict strobes the predictor, redirects the PC, clears the queue
//   (all younger entries are wrong-path) and holds flush for FLUSH_CYC
//   non-stall cycles.
//
// Ports
//   clk, rst_n      clock; synchronous active-low reset
//   stall           freezes all state; strobes drop to 0
//   pred_valid      branch fetched this cycle
//   pred_taken      predictor outcome for that branch
//   pred_alt_pc     PC to use if the prediction turns out wrong
//   res_valid       EX resolves the oldest outstanding branch
//   res_taken       actual outcome
//   fetch_hold      IF must not present new branches (full or flushing)
//   q_count         outstanding entries
//   pre_wrong       1-cycle mispredict strobe to the predictor
//   redirect_valid  1-cycle PC redirect strobe
//   redirect_pc     redirect target, valid with redirect_valid
//   flush           squash IF/ID and ID/EX
//   br_count        resolved branches (saturating)
//   miss_count      mispredicts (saturating)
//   err             sticky protocol error (push while full, resolve while empty)
module branch_resolve_ctrl #(
  parameter int DEPTH     = 4,
  parameter int PC_W      = 32,
  parameter int FLUSH_CYC = 2,
  parameter int CNT_W     = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     stall,
  input  logic                     pred_valid,
  input  logic                     pred_taken,
  input  logic [PC_W-1:0]          pred_alt_pc,
  input  logic                     res_valid,
  input  logic                     res_taken,
  output logic                     fetch_hold,
  output logic [$clog2(DEPTH):0]   q_count,
  output logic                     pre_wrong,
  output logic                     redirect_valid,
  output logic [PC_W-1:0]          redirect_pc,
  output logic                     flush,
  output logic [CNT_W-1:0]         br_count,
  output logic [CNT_W-1:0]         miss_count,
  output logic                     err
);

  localparam int AW   = $clog2(DEPTH);
  localparam int QW   = AW + 1;
  localparam int FC_W = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

  typedef enum logic {S_RUN, S_FLUSH} state_t;

  state_t          state, state_next;
  logic [FC_W-1:0] fcnt, fcnt_next;
  logic            flush_next;

  logic [PC_W:0]   mem [DEPTH];
  logic [AW-1:0]   rd_ptr, wr_ptr;
  logic [QW-1:0]   count;

  logic            run_act, pop, mispredict, good_pop, full;
  logic            push_req, push, push_err, empty_err;
  logic            head_taken;
  logic [PC_W-1:0] head_alt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign head_taken = mem[rd_ptr][PC_W];
  assign head_alt   = mem[rd_ptr][PC_W-1:0];
  assign full       = (count == QW'(DEPTH));

  // Inputs only act in RUN and outside stall; in FLUSH they are wrong-path.
  assign run_act    = (state == S_RUN) && !stall;
  assign pop        = run_act && res_valid && (count != '0);
  assign mispredict = pop && (res_taken != head_taken);
  assign good_pop   = pop && !mispredict;
  assign push_req   = run_act && pred_valid;
  // A full queue still accepts a push when a correct pop frees the head slot.
  assign push       = push_req && !mispredict && (!full || good_pop);
  assign push_err   = push_req && full && !good_pop;
  assign empty_err  = run_act && res_valid && (count == '0);

  assign fetch_hold = full | (state == S_FLUSH);
  assign q_count    = count;

  // fcnt counts the remaining flush cycles after the current one.
  always_comb begin
    state_next = state;
    fcnt_next  = fcnt;
    flush_next = flush;
    if (!stall) begin
      case (state)
        S_RUN: begin
          if (mispredict) begin
            state_next = S_FLUSH;
            fcnt_next  = FC_W'(FLUSH_CYC - 1);
            flush_next = 1'b1;
          end
        end
        S_FLUSH: begin
          if (fcnt == '0) begin
            state_next = S_RUN;
            flush_next = 1'b0;
          end else begin
            fcnt_next = fcnt - FC_W'(1);
          end
        end
        default: state_next = S_RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= S_RUN;
      fcnt           <= '0;
      flush          <= 1'b0;
      pre_wrong      <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      rd_ptr         <= '0;
      wr_ptr         <= '0;
      count          <= '0;
      br_count       <= '0;
      miss_count     <= '0;
      err            <= 1'b0;
    end else begin
      state          <= state_next;
      fcnt           <= fcnt_next;
      flush          <= flush_next;
      pre_wrong      <= mispredict;
      redirect_valid <= mispredict;
      if (mispredict) begin
        redirect_pc <= head_alt;
        miss_count  <= sat_inc(miss_count);
        rd_ptr      <= '0;
        wr_ptr      <= '0;
        count       <= '0;
      end else begin
        if (push)     wr_ptr <= wr_ptr + AW'(1);
        if (good_pop) rd_ptr <= rd_ptr + AW'(1);
        if (push && !good_pop)      count <= count + QW'(1);
        else if (!push && good_pop) count <= count - QW'(1);
      end
      if (pop)                   br_count <= sat_inc(br_count);
      if (push_err || empty_err) err      <= 1'b1;
    end
  end

  // Queue storage carries data only and needs no reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {pred_taken, pred_alt_pc};
  end

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
module tb_branch_resolve_ctrl;
  localparam int DEPTH     = 4;
  localparam int PC_W      = 32;
  localparam int FLUSH_CYC = 2;
  localparam int CNT_W     = 4;
  localparam int CMAX      = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   rst_n, stall, pred_valid, pred_taken, res_valid, res_taken;
  logic [PC_W-1:0]        pred_alt_pc;
  logic                   fetch_hold, pre_wrong, redirect_valid, flush, err;
  logic [$clog2(DEPTH):0] q_count;
  logic [PC_W-1:0]        redirect_pc;
  logic [CNT_W-1:0]       br_count, miss_count;

  branch_resolve_ctrl #(.DEPTH(DEPTH), .PC_W(PC_W), .FLUSH_CYC(FLUSH_CYC), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_alt_pc(pred_alt_pc),
    .res_valid(res_valid), .res_taken(res_taken),
    .fetch_hold(fetch_hold), .q_count(q_count), .pre_wrong(pre_wrong),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .flush(flush),
    .br_count(br_count), .miss_count(miss_count), .err(err)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: queue of outstanding branches plus remaining flush cycles.
  typedef struct packed {
    logic            taken;
    logic [PC_W-1:0] alt;
  } ent_t;
  ent_t            mq[$];
  int              m_fl, m_br, m_miss;
  bit              m_pw, m_rd, m_err;
  logic [PC_W-1:0] m_rpc;

  task automatic model_step();
    int sz;
    bit mis, ok;
    if (!rst_n) begin
      mq.delete(); m_fl = 0; m_pw = 0; m_rd = 0; m_rpc = '0;
      m_br = 0; m_miss = 0; m_err = 0;
      return;
    end
    m_pw = 0; m_rd = 0;
    if (stall) return;
    if (m_fl > 0) begin m_fl--; return; end
    sz = mq.size(); mis = 0; ok = 0;
    if (res_valid) begin
      if (sz == 0) m_err = 1;
      else begin
        if (m_br < CMAX) m_br++;
        if (res_taken != mq[0].taken) mis = 1; else ok = 1;
      end
    end
    if (pred_valid && sz == DEPTH && !ok) m_err = 1;
    if (mis) begin
      m_rpc = mq[0].alt; m_pw = 1; m_rd = 1;
      if (m_miss < CMAX) m_miss++;
      mq.delete();
      m_fl = FLUSH_CYC;
    end else begin
      if (ok) void'(mq.pop_front());
      if (pred_valid && (sz < DEPTH || ok)) mq.push_back('{taken: pred_taken, alt: pred_alt_pc});
    end
  endtask

  task automatic step(input bit r, s, pv, pt, input logic [31:0] pc, input bit rv, rt);
    rst_n = r; stall = s; pred_valid = pv; pred_taken = pt; pred_alt_pc = pc;
    res_valid = rv; res_taken = rt;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic check_model(input int cyc);
    string p;
    p = $sformatf("rnd%0d_", cyc);
    chk({p, "q_count"},    32'(q_count),        32'(mq.size()));
    chk({p, "fetch_hold"}, 32'(fetch_hold),     32'((mq.size() == DEPTH) || (m_fl > 0)));
    chk({p, "flush"},      32'(flush),          32'(m_fl > 0));
    chk({p, "pre_wrong"},  32'(pre_wrong),      32'(m_pw));
    chk({p, "redir_vld"},  32'(redirect_valid), 32'(m_rd));
    chk({p, "redir_pc"},   redirect_pc,         m_rpc);
    chk({p, "br_count"},   32'(br_count),       32'(m_br));
    chk({p, "miss_count"}, 32'(miss_count),     32'(m_miss));
    chk({p, "err"},        32'(err),            32'(m_err));
  endtask

  typedef struct {
    bit r, s, pv, pt; logic [31:0] pc; bit rv, rt;
    bit fh; int q; bit pw, rd; logic [31:0] rpc; bit fl; int br, miss; bit er;
  } vec_t;
  vec_t tv[$];

  function automatic vec_t v(bit r, s, pv, pt, logic [31:0] pc, bit rv, rt,
                             bit fh, int q, bit pw, rd, logic [31:0] rpc, bit fl, int br, miss, bit er);
    vec_t x;
    x.r = r; x.s = s; x.pv = pv; x.pt = pt; x.pc = pc; x.rv = rv; x.rt = rt;
    x.fh = fh; x.q = q; x.pw = pw; x.rd = rd; x.rpc = rpc; x.fl = fl;
    x.br = br; x.miss = miss; x.er = er;
    return x;
  endfunction

  initial begin
    rst_n = 0; stall = 0; pred_valid = 0; pred_taken = 0; pred_alt_pc = '0;
    res_valid = 0; res_taken = 0;

    //          r s pv pt pc      rv rt | fh q pw rd rpc     fl br miss err
    tv.push_back(v(0,0,0,0,32'h0,   0,0,  0,0,0,0,32'h0,   0,0,0,0));
    tv.push_back(v(1,0,1,0,32'h10,  0,0,  0,1,0,0,32'h0,   0,0,0,0));
    tv.push_back(v(1,0,1,0,32'h20,  0,0,  0,2,0,0,32'h0,   0,0,0,0));
    tv.push_back(v(1,0,0,0,32'h0,   1,0,  0,1,0,0,32'h0,   0,1,0,0));
    tv.push_back(v(1,0,0,0,32'h0,   1,0,  0,0,0,0,32'h0,   0,2,0,0));
    tv.push_back(v(1,0,1,1,32'h104, 0,0,  0,1,0,0,32'h0,   0,2,0,0));
    tv.push_back(v(1,0,0,0,32'h0,   1,0,  1,0,1,1,32'h104, 1,3,1,0));
    tv.push_back(v(1,0,0,0,32'h0,   0,0,  1,0,0,0,32'h104, 1,3,1,0));
    tv.push_back(v(1,0,0,0,32'h0,   0,0,  0,0,0,0,32'h104, 0,3,1,0));
    tv.push_back(v(1,0,1,0,32'h200, 0,0,  0,1,0,0,32'h104, 0,3,1,0));
    tv.push_back(v(1,0,1,0,32'h204, 0,0,  0,2,0,0,32'h104, 0,3,1,0));
    tv.push_back(v(1,0,1,0,32'h208, 0,0,  0,3,0,0,32'h104, 0,3,1,0));
    tv.push_back(v(1,0,1,0,32'h20c, 0,0,  1,4,0,0,32'h104, 0,3,1,0));
    tv.push_back(v(1,0,1,1,32'h210, 1,0,  1,4,0,0,32'h104, 0,4,1,0));
    tv.push_back(v(1,0,0,0,32'h0,   1,1,  1,0,1,1,32'h204, 1,5,2,0));
    tv.push_back(v(1,0,0,0,32'h0,   0,0,  1,0,0,0,32'h204, 1,5,2,0));
    tv.push_back(v(1,0,0,0,32'h0,   0,0,  0,0,0,0,32'h204, 0,5,2,0));
    tv.push_back(v(1,0,1,1,32'h300, 0,0,  0,1,0,0,32'h204, 0,5,2,0));
    tv.push_back(v(1,0,1,1,32'h304, 0,0,  0,2,0,0,32'h204, 0,5,2,0));
    tv.push_back(v(1,0,1,1,32'h308, 0,0,  0,3,0,0,32'h204, 0,5,2,0));
    tv.push_back(v(1,0,1,0,32'h30c, 1,0,  1,0,1,1,32'h300, 1,6,3,0));
    tv.push_back(v(1,0,1,1,32'h310, 1,1,  1,0,0,0,32'h300, 1,6,3,0));
    tv.push_back(v(1,0,1,0,32'h314, 1,0,  0,0,0,0,32'h300, 0,6,3,0));
    tv.push_back(v(1,0,0,0,32'h0,   1,0,  0,0,0,0,32'h300, 0,6,3,1));
    tv.push_back(v(1,0,0,0,32'h0,   0,0,  0,0,0,0,32'h300, 0,6,3,1));
    tv.push_back(v(1,0,1,0,32'h400, 0,0,  0,1,0,0,32'h300, 0,6,3,1));
    tv.push_back(v(1,0,0,0,32'h0,   1,1,  1,0,1,1,32'h400, 1,7,4,1));
    tv.push_back(v(0,0,0,0,32'h0,   0,0,  0,0,0,0,32'h0,   0,0,0,0));
    tv.push_back(v(1,0,1,0,32'h500, 0,0,  0,1,0,0,32'h0,   0,0,0,0));
    tv.push_back(v(1,0,1,0,32'h504, 0,0,  0,2,0,0,32'h0,   0,0,0,0));
    tv.push_back(v(1,0,1,0,32'h508, 0,0,  0,3,0,0,32'h0,   0,0,0,0));
    tv.push_back(v(1,0,1,0,32'h50c, 0,0,  1,4,0,0,32'h0,   0,0,0,0));
    tv.push_back(v(1,0,1,0,32'h510, 0,0,  1,4,0,0,32'h0,   0,0,0,1));

    for (int i = 0; i < tv.size(); i++) begin
      step(tv[i].r, tv[i].s, tv[i].pv, tv[i].pt, tv[i].pc, tv[i].rv, tv[i].rt);
      chk($sformatf("v%0d_fetch_hold", i), 32'(fetch_hold),     32'(tv[i].fh));
      chk($sformatf("v%0d_q_count", i),    32'(q_count),        32'(tv[i].q));
      chk($sformatf("v%0d_pre_wrong", i),  32'(pre_wrong),      32'(tv[i].pw));
      chk($sformatf("v%0d_redir_vld", i),  32'(redirect_valid), 32'(tv[i].rd));
      chk($sformatf("v%0d_redir_pc", i),   redirect_pc,         tv[i].rpc);
      chk($sformatf("v%0d_flush", i),      32'(flush),          32'(tv[i].fl));
      chk($sformatf("v%0d_br_count", i),   32'(br_count),       32'(tv[i].br));
      chk($sformatf("v%0d_miss_count", i), 32'(miss_count),     32'(tv[i].miss));
      chk($sformatf("v%0d_err", i),        32'(err),            32'(tv[i].er));
    end

    // Stall freezes a pending resolve, then stretches a flush.
    step(0,0,0,0,0,0,0);
    step(1,0,1,0,32'h700,0,0);
    for (int i = 0; i < 3; i++) begin
      step(1,1,0,0,0,1,0);
      chk($sformatf("stall%0d_q", i),  32'(q_count),  32'd1);
      chk($sformatf("stall%0d_br", i), 32'(br_count), 32'd0);
    end
    step(1,0,0,0,0,1,0);
    chk("unstall_q",  32'(q_count),  32'd0);
    chk("unstall_br", 32'(br_count), 32'd1);
    step(1,0,1,1,32'h800,0,0);
    step(1,0,0,0,0,1,0);
    chk("sflush_pw",  32'(pre_wrong),   32'd1);
    chk("sflush_pc",  redirect_pc,      32'h800);
    chk("sflush_fl0", 32'(flush),       32'd1);
    step(1,1,0,0,0,1,0);
    chk("sflush_pw_drop", 32'(pre_wrong), 32'd0);
    chk("sflush_fl1",     32'(flush),     32'd1);
    step(1,1,0,0,0,0,0);
    chk("sflush_fl2", 32'(flush), 32'd1);
    step(1,0,0,0,0,0,0);
    chk("sflush_fl3", 32'(flush), 32'd1);
    step(1,0,0,0,0,0,0);
    chk("sflush_fl4", 32'(flush),      32'd0);
    chk("sflush_fh4", 32'(fetch_hold), 32'd0);
    chk("sflush_br",  32'(br_count),   32'd2);

    // br_count saturates at all-ones.
    step(0,0,0,0,0,0,0);
    step(1,0,1,0,32'h900,0,0);
    for (int i = 0; i < 20; i++) step(1,0,1,0,32'h904 + 32'(4*i),1,0);
    chk("sat_br", 32'(br_count), 32'(CMAX));
    chk("sat_q",  32'(q_count),  32'd1);

    // Randomised traffic against the reference model.
    step(0,0,0,0,0,0,0);
    for (int c = 0; c < 4000; c++) begin
      step(($urandom_range(99) >= 2), ($urandom_range(99) < 15), ($urandom_range(1) == 1),
           ($urandom_range(1) == 1), $urandom, ($urandom_range(99) < 40), ($urandom_range(1) == 1));
      check_model(c);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
